uart_word_assembler: RTL and testbench

Byte-to-word packet assembler directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobes and end-of-packet pulse. It frames each packet as a length byte followed by payload, packs the payload little-endian into WORD_BYTES-wide words, and buffers the words in a show-ahead FIFO. The FIFO feeds the matrix loader through a valid/ready handshake and marks the last word of each packet.

---
 rtl/uart_word_assembler.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_word_assembler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_assembler.sv
// uart_word_assembler
// Packs UART receiver bytes into little-endian words. Each packet is a
// length byte N (number of words) followed by N*WORD_BYTES payload bytes.
// Completed words are queued in a show-ahead FIFO and presented on a
// valid/ready interface. The last word of each packet carries out_last.
// A packet cut short by rx_endofpacket is closed with a zero-padded word
// that carries out_last=1 and out_err=1.
//
// Optional feature macro: UART_ASM_STATS_EN adds pkt_count / err_count.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   rx_data               received byte, qualified by rx_data_ready
//   rx_data_ready         one-cycle byte strobe
//   rx_endofpacket        one-cycle end-of-burst pulse
//   out_data/last/err     FIFO head word and its flags (0 while empty)
//   out_valid/out_ready   consumer handshake
//   overflow              sticky: a word was dropped on a full FIFO
//   pkt_err               one-cycle pulse when a pad word is produced
//   pkt_count/err_count   (UART_ASM_STATS_EN) saturating statistics
module uart_word_assembler #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_data_ready,
  input  logic                      rx_endofpacket,
  output logic [8*WORD_BYTES-1:0]   out_data,
  output logic                      out_last,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow,
  output logic                      pkt_err
`ifdef UART_ASM_STATS_EN
  ,
  output logic [15:0]               pkt_count,
  output logic [15:0]               err_count
`endif
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = W + 2;
  localparam logic [3:0] LAST_LANE = 4'(WORD_BYTES - 1);

  typedef enum logic [0:0] {
    WAIT_LEN = 1'b0,
    COLLECT  = 1'b1
  } state_t;

  state_t          state_r, nextState_s;
  logic [3:0]      byteCnt_r, nextByteCnt_s;
  logic [7:0]      wordsLeft_r, nextWordsLeft_s;
  logic [W-1:0]    wordBuf_r, nextWordBuf_s;
  logic            pendingPad_r, nextPending_s;
  logic [W-1:0]    assembled_s;
  logic            push_s, pushLast_s, pushErr_s, trunc_s;
  logic [W-1:0]    pushWord_s;

  logic [EW-1:0]   mem_r [FIFO_DEPTH];
  logic [AW:0]     wrPtr_r, rdPtr_r;
  logic            full_s, empty_s, pop_s, write_s, drop_s;
  logic [EW-1:0]   head_s;
  logic            overflow_r, pktErr_r;

  // Place byte b into lane 'lane' of word, little-endian.
  function automatic logic [W-1:0] insertByte(input logic [W-1:0] word,
                                              input logic [3:0]   lane,
                                              input logic [7:0]   b);
    logic [W-1:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Assembly next-state logic: byte packing, word pushes and truncation.
  always_comb begin
    nextState_s     = state_r;
    nextByteCnt_s   = byteCnt_r;
    nextWordsLeft_s = wordsLeft_r;
    nextWordBuf_s   = wordBuf_r;
    nextPending_s   = 1'b0;
    assembled_s     = wordBuf_r;
    push_s          = 1'b0;
    pushWord_s      = {W{1'b0}};
    pushLast_s      = 1'b0;
    pushErr_s       = 1'b0;
    trunc_s         = 1'b0;

    // A pad deferred from last cycle (its packet ended on the same edge a
    // non-final word completed, so two pushes were needed). The FSM is in
    // WAIT_LEN now, which never pushes, so there is no contention.
    if (pendingPad_r) begin
      push_s     = 1'b1;
      pushLast_s = 1'b1;
      pushErr_s  = 1'b1;
      trunc_s    = 1'b1;
    end else begin
      push_s     = 1'b0;
    end

    case (state_r)
      WAIT_LEN: begin
        if (rx_data_ready) begin
          if (rx_data != 8'd0) begin
            nextWordsLeft_s = rx_data;
            nextByteCnt_s   = 4'd0;
            nextWordBuf_s   = {W{1'b0}};
            nextState_s     = COLLECT;
          end else begin
            nextState_s     = WAIT_LEN;
          end
        end else begin
          nextState_s = WAIT_LEN;
        end
      end

      COLLECT: begin
        if (rx_data_ready) begin
          assembled_s = insertByte(wordBuf_r, byteCnt_r, rx_data);
          if (byteCnt_r == LAST_LANE) begin
            push_s          = 1'b1;
            pushWord_s      = assembled_s;
            pushLast_s      = (wordsLeft_r == 8'd1);
            nextByteCnt_s   = 4'd0;
            nextWordBuf_s   = {W{1'b0}};
            nextWordsLeft_s = wordsLeft_r - 8'd1;
            if (wordsLeft_r == 8'd1) begin
              nextState_s = WAIT_LEN;
            end else if (rx_endofpacket) begin
              // Word boundary reached but packet incomplete: all-zero pad next cycle.
              nextPending_s = 1'b1;
              nextState_s   = WAIT_LEN;
            end else begin
              nextState_s = COLLECT;
            end
          end else begin
            nextByteCnt_s = byteCnt_r + 4'd1;
            nextWordBuf_s = assembled_s;
            if (rx_endofpacket) begin
              push_s        = 1'b1;
              pushWord_s    = assembled_s;
              pushLast_s    = 1'b1;
              pushErr_s     = 1'b1;
              trunc_s       = 1'b1;
              nextByteCnt_s = 4'd0;
              nextWordBuf_s = {W{1'b0}};
              nextState_s   = WAIT_LEN;
            end else begin
              nextState_s = COLLECT;
            end
          end
        end else if (rx_endofpacket) begin
          // Unfilled lanes of wordBuf_r are already zero.
          push_s        = 1'b1;
          pushWord_s    = wordBuf_r;
          pushLast_s    = 1'b1;
          pushErr_s     = 1'b1;
          trunc_s       = 1'b1;
          nextByteCnt_s = 4'd0;
          nextWordBuf_s = {W{1'b0}};
          nextState_s   = WAIT_LEN;
        end else begin
          nextState_s = COLLECT;
        end
      end

      default: begin
        nextState_s = WAIT_LEN;
      end
    endcase
  end

  // Assembly state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= WAIT_LEN;
      byteCnt_r    <= 4'd0;
      wordsLeft_r  <= 8'd0;
      wordBuf_r    <= {W{1'b0}};
      pendingPad_r <= 1'b0;
    end else begin
      state_r      <= nextState_s;
      byteCnt_r    <= nextByteCnt_s;
      wordsLeft_r  <= nextWordsLeft_s;
      wordBuf_r    <= nextWordBuf_s;
      pendingPad_r <= nextPending_s;
    end
  end

  // FIFO status: extra pointer MSB distinguishes full from empty.
  assign empty_s = (wrPtr_r == rdPtr_r);
  assign full_s  = (wrPtr_r[AW] != rdPtr_r[AW]) &&
                   (wrPtr_r[AW-1:0] == rdPtr_r[AW-1:0]);
  assign pop_s   = !empty_s && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign write_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;
  assign head_s  = mem_r[rdPtr_r[AW-1:0]];

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_r <= {(AW+1){1'b0}};
      rdPtr_r <= {(AW+1){1'b0}};
    end else begin
      if (write_s) begin
        wrPtr_r <= wrPtr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // FIFO storage: {err, last, data}.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wrPtr_r[AW-1:0]] <= {pushErr_s, pushLast_s, pushWord_s};
    end
  end

  // Sticky overflow flag and registered truncation pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
      pktErr_r   <= 1'b0;
    end else begin
      overflow_r <= overflow_r | drop_s;
      pktErr_r   <= trunc_s;
    end
  end

  // Head-of-FIFO outputs, forced to zero while empty.
  always_comb begin
    if (empty_s) begin
      out_data = {W{1'b0}};
      out_last = 1'b0;
      out_err  = 1'b0;
    end else begin
      out_data = head_s[W-1:0];
      out_last = head_s[W];
      out_err  = head_s[W+1];
    end
  end

  assign out_valid = !empty_s;
  assign overflow  = overflow_r;
  assign pkt_err   = pktErr_r;

`ifdef UART_ASM_STATS_EN
  logic [15:0] pktCount_r, errCount_r;

  // Saturating packet and error statistics; a dropped word still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      pktCount_r <= 16'd0;
      errCount_r <= 16'd0;
    end else begin
      if (push_s && pushLast_s && !pushErr_s && (pktCount_r != 16'hFFFF)) begin
        pktCount_r <= pktCount_r + 16'd1;
      end
      if (pktErr_r && (errCount_r != 16'hFFFF)) begin
        errCount_r <= errCount_r + 16'd1;
      end
    end
  end

  assign pkt_count = pktCount_r;
  assign err_count = errCount_r;
`endif

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed testbench for uart_word_assembler (WORD_BYTES=4, FIFO_DEPTH=16).
// Popped words are captured by a monitor; expected values are hand-computed.
module tb_uart_word_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_ready = 1'b0;
  logic        rx_endofpacket = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic        pkt_err;
`ifdef UART_ASM_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] err_count;
`endif

  uart_word_assembler #(.WORD_BYTES(4), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .rx_endofpacket(rx_endofpacket), .out_data(out_data), .out_last(out_last),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .pkt_err(pkt_err)
`ifdef UART_ASM_STATS_EN
    , .pkt_count(pkt_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFails   = 0;
  logic [33:0] popQ[$];   // {err, last, data}
  int errHigh = 0;        // cycles with pkt_err high

  // Monitor: capture every accepted word and count pkt_err cycles.
  always @(posedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) popQ.push_back({out_err, out_last, out_data});
      if (pkt_err) errHigh <= errHigh + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic eop);
    rx_data = b; rx_data_ready = 1'b1; rx_endofpacket = eop;
    @(posedge clk); #1;
    rx_data_ready = 1'b0; rx_endofpacket = 1'b0; rx_data = 8'h00;
  endtask

  task automatic sendEop();
    rx_endofpacket = 1'b1;
    @(posedge clk); #1;
    rx_endofpacket = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int base;
  int e0;

  initial begin
    doReset();
    // Reset state
    check("rst_valid", out_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_pkt_err", pkt_err, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_last", out_last, 1'b0);
    check("rst_err", out_err, 1'b0);

    // Two-word packet, consumer always ready
    out_ready = 1'b1;
    base = popQ.size(); e0 = errHigh;
    sendByte(8'h02, 1'b0);
    sendByte(8'h11, 1'b0); sendByte(8'h22, 1'b0);
    sendByte(8'h33, 1'b0); sendByte(8'h44, 1'b0);
    check("t1_lat_valid", out_valid, 1'b1);
    check("t1_lat_data", out_data, 32'h44332211);
    sendByte(8'h55, 1'b0); sendByte(8'h66, 1'b0);
    sendByte(8'h77, 1'b0); sendByte(8'h88, 1'b0);
    idle(3);
    check("t1_count", popQ.size() - base, 2);
    check("t1_w0", popQ[base], {2'b00, 32'h44332211});
    check("t1_w1", popQ[base+1], {2'b01, 32'h88776655});
    check("t1_pkt_err", errHigh - e0, 0);

    // Zero length byte ignored, then a one-word packet
    base = popQ.size(); e0 = errHigh;
    sendByte(8'h00, 1'b0);
    sendEop();
    idle(2);
    check("t2_none", popQ.size() - base, 0);
    check("t2_no_err", errHigh - e0, 0);
    check("t2_valid", out_valid, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'hAA, 1'b0); sendByte(8'hBB, 1'b0);
    sendByte(8'hCC, 1'b0); sendByte(8'hDD, 1'b0);
    idle(3);
    check("t2_count", popQ.size() - base, 1);
    check("t2_w0", popQ[base], {2'b01, 32'hDDCCBBAA});

    // Truncation with a partial word
    base = popQ.size(); e0 = errHigh;
    sendByte(8'h02, 1'b0);
    sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0); sendByte(8'h04, 1'b0);
    sendByte(8'h05, 1'b0);
    sendEop();
    check("t3_pkt_err_hi", pkt_err, 1'b1);
    check("t3_pad_data", out_data, 32'h00000005);
    check("t3_pad_flags", {out_err, out_last}, 2'b11);
    idle(1);
    check("t3_pkt_err_lo", pkt_err, 1'b0);
    idle(2);
    check("t3_count", popQ.size() - base, 2);
    check("t3_w0", popQ[base], {2'b00, 32'h04030201});
    check("t3_pad", popQ[base+1], {2'b11, 32'h00000005});
    check("t3_err_cycles", errHigh - e0, 1);

    // Final byte and end-of-packet together: no pad
    base = popQ.size(); e0 = errHigh;
    sendByte(8'h01, 1'b0);
    sendByte(8'hAA, 1'b0); sendByte(8'hBB, 1'b0);
    sendByte(8'hCC, 1'b0); sendByte(8'hDD, 1'b1);
    idle(3);
    check("t3b_count", popQ.size() - base, 1);
    check("t3b_w0", popQ[base], {2'b01, 32'hDDCCBBAA});
    check("t3b_no_err", errHigh - e0, 0);

    // Word completes on end-of-packet, packet incomplete: word then zero pad
    base = popQ.size(); e0 = errHigh;
    sendByte(8'h02, 1'b0);
    sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0); sendByte(8'h04, 1'b1);
    idle(3);
    check("t3c_count", popQ.size() - base, 2);
    check("t3c_w0", popQ[base], {2'b00, 32'h04030201});
    check("t3c_pad", popQ[base+1], {2'b11, 32'h00000000});
    check("t3c_err_cycles", errHigh - e0, 1);

    // Overflow: 17-word packet into a stalled 16-entry FIFO
    doReset();
    out_ready = 1'b0;
    sendByte(8'h11, 1'b0);
    for (int i = 0; i < 68; i++) sendByte(8'(i + 1), 1'b0);
    check("t4_valid", out_valid, 1'b1);
    check("t4_overflow", overflow, 1'b1);
    check("t4_head", out_data, 32'h04030201);
    check("t4_head_last", out_last, 1'b0);
    idle(5);
    check("t4_stable", out_data, 32'h04030201);
    base = popQ.size();
    out_ready = 1'b1;
    idle(20);
    check("t4_drained", popQ.size() - base, 16);
    check("t4_first", popQ[base], {2'b00, 32'h04030201});
    check("t4_16th", popQ[base+15], {2'b00, 32'h403F3E3D});
    check("t4_empty", out_valid, 1'b0);
    check("t4_sticky", overflow, 1'b1);
    base = popQ.size();
    sendByte(8'h01, 1'b0);
    sendByte(8'hAA, 1'b0); sendByte(8'hBB, 1'b0);
    sendByte(8'hCC, 1'b0); sendByte(8'hDD, 1'b0);
    idle(3);
    check("t4_next_count", popQ.size() - base, 1);
    check("t4_next", popQ[base], {2'b01, 32'hDDCCBBAA});

    // Full FIFO: push and pop on the same edge
    doReset();
    out_ready = 1'b0;
    sendByte(8'h10, 1'b0);
    for (int i = 0; i < 64; i++) sendByte(8'(i + 1), 1'b0);
    check("t5_full_no_ovf", overflow, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'hAA, 1'b0); sendByte(8'hBB, 1'b0); sendByte(8'hCC, 1'b0);
    rx_data = 8'hDD; rx_data_ready = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rx_data_ready = 1'b0; out_ready = 1'b0; rx_data = 8'h00;
    check("t5_overflow", overflow, 1'b0);
    check("t5_head", out_data, 32'h08070605);
    base = popQ.size();
    out_ready = 1'b1;
    idle(20);
    check("t5_occupancy", popQ.size() - base, 16);
    check("t5_w15", popQ[base+14], {2'b01, 32'h403F3E3D});
    check("t5_new", popQ[base+15], {2'b01, 32'hDDCCBBAA});

    // Reset mid-packet with queued words
    out_ready = 1'b0;
    sendByte(8'h01, 1'b0);
    sendByte(8'h55, 1'b0); sendByte(8'h66, 1'b0);
    sendByte(8'h77, 1'b0); sendByte(8'h88, 1'b0);
    sendByte(8'h02, 1'b0); sendByte(8'h11, 1'b0); sendByte(8'h22, 1'b0);
    check("t6_queued", out_valid, 1'b1);
    doReset();
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_data", out_data, 32'h0);
    out_ready = 1'b1;
    base = popQ.size();
    sendByte(8'h01, 1'b0);
    sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0); sendByte(8'h04, 1'b0);
    idle(3);
    check("t6_count", popQ.size() - base, 1);
    check("t6_w0", popQ[base], {2'b01, 32'h04030201});
`ifdef UART_ASM_STATS_EN
    check("stats_pkt", pkt_count, 16'd1);
    check("stats_err", err_count, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
